// File: rtl/aes_pkg.sv
// Shared defaults and helpers for the AES output serializer slice.
package aes_pkg;

  localparam int unsigned DATA_W        = 128;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORDS_PER_BLK = DATA_W / WORD_W;
  localparam int unsigned DEPTH         = 2;

  // Index/pointer width that never collapses to zero bits.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// Word stream from the serializer to the downstream consumer.
interface aes_out_serializer_if #(
  parameter int unsigned WORD_W = aes_pkg::WORD_W
);

  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [WORD_W-1:0] out_data;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/aes_blk_fifo.sv
// Block FIFO: DEPTH entries of DATA_W bits, storage left unreset.
module aes_blk_fifo
  import aes_pkg::*;
#(
  parameter  int unsigned DATA_W = aes_pkg::DATA_W,
  parameter  int unsigned DEPTH  = aes_pkg::DEPTH,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_c,
  output logic              empty_c,
  output logic [LVL_W-1:0]  level_o,
  output logic [DATA_W-1:0] head_c,
  output logic [DATA_W-1:0] second_c,
  output logic [LVL_W-1:0]  level_nxt_c
);

  localparam int unsigned PTR_W = min1_clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  level_q, level_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointers and occupancy.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push_i) wr_d = ptr_inc(wr_q);
    if (pop_i)  rd_d = ptr_inc(rd_q);
    if (push_i && !pop_i)      level_d = level_q + LVL_W'(1);
    else if (!push_i && pop_i) level_d = level_q - LVL_W'(1);
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Block storage.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign full_c      = (level_q == LVL_W'(DEPTH));
  assign empty_c     = (level_q == '0);
  assign level_o     = level_q;
  assign head_c      = mem_q[rd_q];
  assign second_c    = mem_q[ptr_inc(rd_q)];
  assign level_nxt_c = level_d;

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES ciphertext blocks and streams them out MSW first.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter  int unsigned DATA_W = aes_pkg::DATA_W,
  parameter  int unsigned WORD_W = aes_pkg::WORD_W,
  parameter  int unsigned DEPTH  = aes_pkg::DEPTH,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        valid_out,
  input  logic [DATA_W-1:0]           cipher_text,
  input  logic                        ovf_clr,
  aes_out_serializer_if.master        out_if,
  output logic [LVL_W-1:0]            level,
  output logic                        overflow
);

  localparam int unsigned WORDS = DATA_W / WORD_W;
  localparam int unsigned IDX_W = min1_clog2(WORDS);

  logic              full_c, empty_c;
  logic [LVL_W-1:0]  level_nxt_c;
  logic [DATA_W-1:0] head_c, second_c;

  logic              xfer, pop, push, drop;
  logic [DATA_W-1:0] blk_nxt, blk_sh;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;

  aes_blk_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (cipher_text),
    .pop_i       (pop),
    .full_c      (full_c),
    .empty_c     (empty_c),
    .level_o     (level),
    .head_c      (head_c),
    .second_c    (second_c),
    .level_nxt_c (level_nxt_c)
  );

  // Handshake decode, overflow, index and the word to present after this edge.
  always_comb begin
    xfer = out_valid_q && out_if.out_ready;
    pop  = xfer && out_last_q && !empty_c;
    push = valid_out && (!full_c || pop);
    drop = valid_out && full_c && !pop;

    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;

    idx_d = idx_q;
    if (pop)       idx_d = '0;
    else if (xfer) idx_d = idx_q + IDX_W'(1);

    // Head block as it will stand after this edge; an empty slot is filled by the push.
    if (pop) blk_nxt = (level == LVL_W'(1)) ? cipher_text : second_c;
    else     blk_nxt = empty_c ? cipher_text : head_c;

    out_valid_d = (level_nxt_c != '0);
    blk_sh      = blk_nxt << (WORD_W * 32'(idx_d));
    out_data_d  = out_valid_d ? blk_sh[DATA_W-1 -: WORD_W] : '0;
    out_last_d  = out_valid_d && (idx_d == IDX_W'(WORDS - 1));
  end

  // Output and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_data  = out_data_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer.
module tb_aes_out_serializer;

  logic         clk;
  logic         reset_n;
  logic         valid_out;
  logic [127:0] cipher_text;
  logic         ovf_clr;
  logic [1:0]   level;
  logic         overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  localparam logic [127:0] C0 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C3 = 128'hdeadbeefcafef00d123456789abcdef0;

  aes_out_serializer_if #(.WORD_W(32)) out_if ();

  aes_out_serializer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_out   (valid_out),
    .cipher_text (cipher_text),
    .ovf_clr     (ovf_clr),
    .out_if      (out_if),
    .level       (level),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic last);
    chk({tag, "_valid"}, 128'(out_if.out_valid), 128'd1);
    chk({tag, "_data"},  128'(out_if.out_data),  128'(w));
    chk({tag, "_last"},  128'(out_if.out_last),  128'(last));
  endtask

  // Expects word 0 already on the output with out_ready=1; leaves the last word showing.
  task automatic check_block(input string tag, input logic [127:0] blk);
    logic [127:0] b;
    b = blk;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      chk_word($sformatf("%s_w%0d", tag, k), b[127-32*k -: 32], k == 3);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 128'(out_if.out_valid), 128'd0);
    chk({tag, "_level"}, 128'(level), 128'd0);
  endtask

  logic [127:0] sblk [4];
  logic [127:0] tmp;

  initial begin
    reset_n          = 1'b0;
    valid_out        = 1'b0;
    cipher_text      = '0;
    ovf_clr          = 1'b0;
    out_if.out_ready = 1'b1;
    sblk[0] = C0; sblk[1] = C1; sblk[2] = C2; sblk[3] = C3;

    // Reset state
    #12;
    chk("rst_valid", 128'(out_if.out_valid), 128'd0);
    chk("rst_data",  128'(out_if.out_data),  128'd0);
    chk("rst_last",  128'(out_if.out_last),  128'd0);
    chk("rst_level", 128'(level),            128'd0);
    chk("rst_ovf",   128'(overflow),         128'd0);
    reset_n = 1'b1;
    tick();
    chk_idle("idle");

    // Single block, out_ready held high
    valid_out = 1'b1; cipher_text = C0;
    tick();
    valid_out = 1'b0;
    chk("single_level", 128'(level), 128'd1);
    chk_word("single_w0", 32'h3925841d, 1'b0);
    tick(); chk_word("single_w1", 32'h02dc09fb, 1'b0);
    tick(); chk_word("single_w2", 32'hdc118597, 1'b0);
    tick(); chk_word("single_w3", 32'h196a0b32, 1'b1);
    tick(); chk_idle("single_end");

    // Backpressure: first word held for 5 stalled cycles
    out_if.out_ready = 1'b0;
    valid_out = 1'b1; cipher_text = C0;
    tick();
    valid_out = 1'b0;
    chk_word("bp_w0", 32'h3925841d, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_word($sformatf("bp_hold%0d", i), 32'h3925841d, 1'b0);
    end
    out_if.out_ready = 1'b1;
    tick(); chk_word("bp_w1", 32'h02dc09fb, 1'b0);
    tick(); chk_word("bp_w2", 32'hdc118597, 1'b0);
    tick(); chk_word("bp_w3", 32'h196a0b32, 1'b1);
    tick(); chk_idle("bp_end");

    // Overflow: third block dropped, sticky flag, clear, drop beats clear
    out_if.out_ready = 1'b0;
    valid_out = 1'b1; cipher_text = C1; tick();
    chk("ovf_lvl1", 128'(level), 128'd1);
    cipher_text = C2; tick();
    chk("ovf_lvl2", 128'(level), 128'd2);
    chk("ovf_not_yet", 128'(overflow), 128'd0);
    cipher_text = C3; tick();
    valid_out = 1'b0;
    chk("ovf_lvl_full", 128'(level), 128'd2);
    chk("ovf_set", 128'(overflow), 128'd1);
    tick();
    chk("ovf_sticky", 128'(overflow), 128'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 128'(overflow), 128'd0);
    valid_out = 1'b1; cipher_text = C3; ovf_clr = 1'b1; tick();
    valid_out = 1'b0; ovf_clr = 1'b0;
    chk("ovf_drop_wins", 128'(overflow), 128'd1);
    chk("ovf_drop_lvl", 128'(level), 128'd2);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", 128'(overflow), 128'd0);
    out_if.out_ready = 1'b1;
    check_block("ovf_c1", C1);
    tick();
    check_block("ovf_c2", C2);
    tick(); chk_idle("ovf_end");

    // Push coinciding with the last-word pop while full
    out_if.out_ready = 1'b0;
    valid_out = 1'b1; cipher_text = C1; tick();
    cipher_text = C2; tick();
    valid_out = 1'b0;
    chk("pp_lvl_full", 128'(level), 128'd2);
    out_if.out_ready = 1'b1;
    check_block("pp_c1", C1);
    valid_out = 1'b1; cipher_text = C3; tick();
    valid_out = 1'b0;
    chk("pp_lvl_kept", 128'(level), 128'd2);
    chk("pp_no_ovf", 128'(overflow), 128'd0);
    check_block("pp_c2", C2);
    tick();
    check_block("pp_c3", C3);
    tick(); chk_idle("pp_end");

    // Streaming: 4 blocks 4 cycles apart, 16 gap-free words
    for (int b = 0; b < 4; b++) begin
      tmp = sblk[b];
      for (int c = 0; c < 4; c++) begin
        if (c == 0) begin
          valid_out = 1'b1; cipher_text = tmp;
        end
        tick();
        valid_out = 1'b0;
        chk_word($sformatf("st_b%0d_w%0d", b, c), tmp[127-32*c -: 32], c == 3);
      end
    end
    tick(); chk_idle("st_end");

    // Reset in the middle of a block
    valid_out = 1'b1; cipher_text = C1; tick();
    valid_out = 1'b0;
    chk_word("mr_w0", 32'h00112233, 1'b0);
    tick(); chk_word("mr_w1", 32'h44556677, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", 128'(out_if.out_valid), 128'd0);
    chk("mr_data",  128'(out_if.out_data),  128'd0);
    chk("mr_last",  128'(out_if.out_last),  128'd0);
    chk("mr_level", 128'(level),            128'd0);
    chk("mr_ovf",   128'(overflow),         128'd0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("mr_quiet%0d", i));
    end
    valid_out = 1'b1; cipher_text = C2; tick();
    valid_out = 1'b0;
    check_block("mr_new", C2);
    tick(); chk_idle("mr_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
